// File: rtl/bash_line_io.sv
// Terminal-side endpoint of the bash line protocol: edits a command line with echo,
// delivers it to a command module, then prints that module's reply and acknowledges it.
module bash_line_io #(
  parameter int MAX_LEN = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kb_valid,
  input  logic [7:0] kb_ascii,
  output logic       vm_we,
  output logic [7:0] vm_char,
  output logic       out_newASCII_ready,
  output logic [5:0] out_lineLen,
  output logic [7:0] lineOut,
  input  logic       lineOut_nextASCII,
  input  logic       in_newASCII_ready,
  input  logic [7:0] lineIn,
  output logic       lineIn_nextASCII,
  input  logic       in_solved,
  output logic       out_solved
);

  typedef enum logic [2:0] {EDIT, DELIVER, TERM, WAIT, OUT, SOLVE} state_t;

  state_t     state;
  logic [7:0] line_buf [32];
  logic [5:0] len;
  logic [5:0] idx;
  logic       printable;
  logic       store;

  assign printable = (kb_ascii >= 8'h20) && (kb_ascii <= 8'h7E);
  assign store     = (state == EDIT) && kb_valid && printable && (len < 6'(MAX_LEN));

  // Character at position n of the current line; the slot at len is the terminator.
  function automatic logic [7:0] char_at(input logic [5:0] n);
    return (n == len) ? 8'h00 : line_buf[n[4:0]];
  endfunction

  always_ff @(posedge clk) begin
    if (store)
      line_buf[len[4:0]] <= kb_ascii;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= EDIT;
      len                <= '0;
      idx                <= '0;
      vm_we              <= 1'b0;
      vm_char            <= '0;
      out_newASCII_ready <= 1'b0;
      out_lineLen        <= '0;
      lineOut            <= '0;
      lineIn_nextASCII   <= 1'b0;
      out_solved         <= 1'b0;
    end else begin
      vm_we            <= 1'b0;
      lineIn_nextASCII <= 1'b0;
      out_solved       <= 1'b0;
      case (state)
        EDIT: begin
          if (kb_valid) begin
            if (printable) begin
              if (len < 6'(MAX_LEN)) begin
                len     <= len + 6'd1;
                vm_we   <= 1'b1;
                vm_char <= kb_ascii;
              end
            end else if (kb_ascii == 8'h08) begin
              if (len != 6'd0) begin
                len     <= len - 6'd1;
                vm_we   <= 1'b1;
                vm_char <= 8'h08;
              end
            end else if ((kb_ascii == 8'h0D) || (kb_ascii == 8'h0A)) begin
              vm_we   <= 1'b1;
              vm_char <= 8'h0A;
              idx     <= '0;
              state   <= DELIVER;
            end
          end
        end
        // The first DELIVER cycle only loads the presentation registers, so the
        // line appears one cycle after the Enter echo.
        DELIVER: begin
          if (!out_newASCII_ready) begin
            out_newASCII_ready <= 1'b1;
            out_lineLen        <= len;
            lineOut            <= char_at(6'd0);
          end else if (idx == len) begin
            state <= TERM;
          end else if (lineOut_nextASCII) begin
            idx     <= idx + 6'd1;
            lineOut <= char_at(idx + 6'd1);
          end
        end
        TERM: begin
          out_newASCII_ready <= 1'b0;
          lineOut            <= 8'h00;
          state              <= WAIT;
        end
        WAIT: begin
          if (in_solved) begin
            out_solved <= 1'b1;
            vm_we      <= 1'b1;
            vm_char    <= 8'h0A;
            state      <= SOLVE;
          end else if (in_newASCII_ready) begin
            state <= OUT;
          end
        end
        // A pending character is only taken when the previous pulse has ended,
        // which limits the reply rate to one character every two cycles.
        OUT: begin
          if (in_solved) begin
            out_solved <= 1'b1;
            vm_we      <= 1'b1;
            vm_char    <= 8'h0A;
            state      <= SOLVE;
          end else if (in_newASCII_ready && (lineIn != 8'h00) && !lineIn_nextASCII) begin
            vm_we            <= 1'b1;
            vm_char          <= lineIn;
            lineIn_nextASCII <= 1'b1;
          end
        end
        SOLVE: begin
          if (!in_solved) begin
            len   <= '0;
            state <= EDIT;
          end
        end
        default: state <= EDIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bash_line_io.sv
// Self-checking bench for bash_line_io: table-driven edit vectors, scripted corner
// cases and randomized lines checked against a queue-based line model.
module tb_bash_line_io;

  typedef logic [7:0] u8;

  typedef struct {
    u8  key;
    bit exp_we;
    u8  exp_char;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kb_valid;
  logic [7:0] kb_ascii;
  logic       vm_we;
  logic [7:0] vm_char;
  logic       out_newASCII_ready;
  logic [5:0] out_lineLen;
  logic [7:0] lineOut;
  logic       lineOut_nextASCII;
  logic       in_newASCII_ready;
  logic [7:0] lineIn;
  logic       lineIn_nextASCII;
  logic       in_solved;
  logic       out_solved;

  int checks   = 0;
  int failures = 0;

  u8 model_line[$];

  bash_line_io #(.MAX_LEN(31)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .kb_valid           (kb_valid),
    .kb_ascii           (kb_ascii),
    .vm_we              (vm_we),
    .vm_char            (vm_char),
    .out_newASCII_ready (out_newASCII_ready),
    .out_lineLen        (out_lineLen),
    .lineOut            (lineOut),
    .lineOut_nextASCII  (lineOut_nextASCII),
    .in_newASCII_ready  (in_newASCII_ready),
    .lineIn             (lineIn),
    .lineIn_nextASCII   (lineIn_nextASCII),
    .in_solved          (in_solved),
    .out_solved         (out_solved)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Editing rules of the terminal expressed directly on a queue of characters.
  task automatic modelKey(input u8 k, output bit we, output u8 ch);
    we = 1'b0;
    ch = 8'h00;
    if (k >= 8'h20 && k <= 8'h7E) begin
      if (model_line.size() < 31) begin
        model_line.push_back(k);
        we = 1'b1;
        ch = k;
      end
    end else if (k == 8'h08) begin
      if (model_line.size() > 0) begin
        void'(model_line.pop_back());
        we = 1'b1;
        ch = 8'h08;
      end
    end else if (k == 8'h0D || k == 8'h0A) begin
      we = 1'b1;
      ch = 8'h0A;
    end
  endtask

  task automatic pressKey(input u8 k);
    kb_valid = 1'b1;
    kb_ascii = k;
    cyc();
    kb_valid = 1'b0;
    kb_ascii = 8'h00;
  endtask

  task automatic typeKey(input u8 k);
    bit we;
    u8  ch;
    modelKey(k, we, ch);
    pressKey(k);
    checkOutput("echo_we", vm_we, we);
    if (we)
      checkOutput("echo_char", vm_char, ch);
  endtask

  task automatic applyStimulus(input vec_t v);
    bit we;
    u8  ch;
    modelKey(v.key, we, ch);
    pressKey(v.key);
    checkOutput("table_echo_we", vm_we, v.exp_we);
    if (v.exp_we)
      checkOutput("table_echo_char", vm_char, v.exp_char);
  endtask

  // Protocol reader with random stalls; call right after the Enter echo cycle.
  task automatic deliverLine(input u8 exp[$]);
    u8  got[$];
    int term = 0;
    checkOutput("ready_low_at_enter_echo", out_newASCII_ready, 0);
    cyc();
    checkOutput("ready_rise", out_newASCII_ready, 1);
    checkOutput("line_len", out_lineLen, exp.size());
    for (int c = 0; c < 400 && out_newASCII_ready; c++) begin
      if (lineOut == 8'h00) begin
        term++;
        lineOut_nextASCII = 1'b1;
      end else begin
        lineOut_nextASCII = 1'($urandom_range(0, 1));
        if (lineOut_nextASCII)
          got.push_back(lineOut);
      end
      cyc();
    end
    lineOut_nextASCII = 1'b0;
    checkOutput("ready_fall", out_newASCII_ready, 0);
    checkOutput("term_cycles", term, 2);
    checkOutput("rx_count", got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      checkOutput("rx_char", got[i], exp[i]);
  endtask

  // Command module that streams rep, then raises in_solved and holds it for
  // hold extra cycles after the acknowledge.
  task automatic runReply(input u8 rep[$], input int hold);
    u8  got[$];
    int pulses = 0, consec = 0, solved = 0, prev = 0, ptr = 0, after = 0, hcnt = 0;
    in_newASCII_ready = 1'b1;
    lineIn = (rep.size() > 0) ? rep[0] : 8'h00;
    for (int c = 0; c < 300; c++) begin
      kb_valid = (solved == 0) && ($urandom_range(0, 3) == 0);
      kb_ascii = kb_valid ? 8'h7A : 8'h00;
      cyc();
      kb_valid = 1'b0;
      if (vm_we)
        got.push_back(vm_char);
      if (lineIn_nextASCII) begin
        pulses++;
        if (prev != 0)
          consec++;
        ptr++;
      end
      prev = int'(lineIn_nextASCII);
      if (out_solved)
        solved++;
      if (solved > 0) begin
        after++;
        if (in_solved) begin
          if (hcnt >= hold)
            in_solved = 1'b0;
          else
            hcnt++;
        end
      end else if (ptr >= rep.size()) begin
        in_newASCII_ready = 1'b0;
        in_solved = 1'b1;
      end
      lineIn = (ptr < rep.size()) ? rep[ptr] : 8'h00;
      if (after >= hold + 3)
        break;
    end
    in_solved = 1'b0;
    in_newASCII_ready = 1'b0;
    lineIn = 8'h00;
    checkOutput("reply_pulses", pulses, rep.size());
    checkOutput("reply_consecutive_pulses", consec, 0);
    checkOutput("solved_pulses", solved, 1);
    checkOutput("reply_vm_count", got.size(), rep.size() + 1);
    for (int i = 0; i < got.size() && i <= rep.size(); i++)
      checkOutput("reply_vm_char", got[i], (i < rep.size()) ? rep[i] : 8'h0A);
    model_line.delete();
  endtask

  initial begin
    vec_t vecs[7];
    u8    exp_q[$];
    u8    rep[$];
    u8    k;

    rst_n = 1'b0;
    kb_valid = 1'b0;
    kb_ascii = 8'h00;
    lineOut_nextASCII = 1'b0;
    in_newASCII_ready = 1'b0;
    lineIn = 8'h00;
    in_solved = 1'b0;

    vecs[0] = '{8'h08, 1'b0, 8'h00};
    vecs[1] = '{8'h01, 1'b0, 8'h00};
    vecs[2] = '{8'h61, 1'b1, 8'h61};
    vecs[3] = '{8'h62, 1'b1, 8'h62};
    vecs[4] = '{8'h08, 1'b1, 8'h08};
    vecs[5] = '{8'h63, 1'b1, 8'h63};
    vecs[6] = '{8'h7F, 1'b0, 8'h00};

    cyc();
    cyc();
    checkOutput("rst_vm_we", vm_we, 0);
    checkOutput("rst_vm_char", vm_char, 0);
    checkOutput("rst_ready", out_newASCII_ready, 0);
    checkOutput("rst_line_len", out_lineLen, 0);
    checkOutput("rst_line_out", lineOut, 0);
    checkOutput("rst_line_in_next", lineIn_nextASCII, 0);
    checkOutput("rst_solved", out_solved, 0);
    rst_n = 1'b1;
    cyc();

    $display("[TB] type and deliver");
    typeKey(8'h6C);
    typeKey(8'h73);
    typeKey(8'h0D);
    exp_q = '{8'h6C, 8'h73};
    deliverLine(exp_q);
    rep = '{8'h68, 8'h69};
    runReply(rep, 2);

    $display("[TB] backspace table");
    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i]);
    typeKey(8'h0D);
    exp_q = '{8'h61, 8'h63};
    deliverLine(exp_q);
    rep.delete();
    runReply(rep, 0);

    $display("[TB] overflow");
    for (int i = 0; i < 33; i++)
      typeKey(8'h78);
    typeKey(8'h0D);
    exp_q.delete();
    for (int i = 0; i < 31; i++)
      exp_q.push_back(8'h78);
    deliverLine(exp_q);
    checkOutput("overflow_final_line_out", lineOut, 0);
    rep = '{8'h6F, 8'h6B};
    runReply(rep, 1);

    $display("[TB] empty line");
    typeKey(8'h0D);
    exp_q.delete();
    deliverLine(exp_q);

    $display("[TB] solved beats pending character");
    in_newASCII_ready = 1'b1;
    lineIn = 8'h71;
    cyc();
    checkOutput("out_entry_no_write", vm_we, 0);
    in_solved = 1'b1;
    cyc();
    checkOutput("race_vm_we", vm_we, 1);
    checkOutput("race_vm_char", vm_char, 8'h0A);
    checkOutput("race_solved", out_solved, 1);
    checkOutput("race_no_pulse", lineIn_nextASCII, 0);
    in_solved = 1'b0;
    in_newASCII_ready = 1'b0;
    lineIn = 8'h00;
    cyc();
    checkOutput("race_solved_once", out_solved, 0);
    cyc();
    model_line.delete();

    $display("[TB] reset mid-delivery");
    typeKey(8'h61);
    typeKey(8'h62);
    typeKey(8'h0D);
    cyc();
    checkOutput("mid_first_char", lineOut, 8'h61);
    lineOut_nextASCII = 1'b1;
    cyc();
    lineOut_nextASCII = 1'b0;
    checkOutput("mid_advance_char", lineOut, 8'h62);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_async_ready_drop", out_newASCII_ready, 0);
    checkOutput("mid_async_line_out", lineOut, 0);
    cyc();
    checkOutput("mid_held_ready", out_newASCII_ready, 0);
    rst_n = 1'b1;
    model_line.delete();
    cyc();
    typeKey(8'h0D);
    exp_q.delete();
    deliverLine(exp_q);
    rep.delete();
    runReply(rep, 0);

    $display("[TB] randomized lines");
    for (int n = 0; n < 15; n++) begin
      int nk;
      nk = $urandom_range(0, 40);
      for (int i = 0; i < nk; i++) begin
        case ($urandom_range(0, 9))
          7: k = 8'h08;
          8: begin
            k = 8'($urandom_range(0, 255));
            if (k == 8'h0D || k == 8'h0A)
              k = 8'h01;
          end
          default: k = 8'($urandom_range(32, 126));
        endcase
        typeKey(k);
        if ($urandom_range(0, 3) == 0)
          cyc();
      end
      typeKey(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
      exp_q = model_line;
      deliverLine(exp_q);
      rep.delete();
      for (int i = 0; i < int'($urandom_range(0, 5)); i++)
        rep.push_back(8'($urandom_range(32, 126)));
      runReply(rep, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bash_line_io.md
# bash_line_io

Terminal-side endpoint of the bash line protocol. Assembles one command line from keyboard ASCII (with echo and backspace), hands it to a command module through the `out_*`/`lineOut*` handshake, then accepts that module's reply through the `in_*`/`lineIn*` handshake, writes it to the video-memory character port, and acknowledges completion. It sits between the keyboard decoder, the video memory writer and any echo-style command module.

## Interface
- `MAX_LEN`, 31: maximum characters per line; the terminator 0x00 is additional.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `kb_valid`  in  1  one-cycle strobe, `kb_ascii` valid.
- `kb_ascii`  in  8  keyboard character.
- `vm_we`  out  1  one-cycle write strobe to the video-memory character port.
- `vm_char`  out  8  character to write; 0x08 = backspace, 0x0A = newline.
- `out_newASCII_ready`  out  1  a line is being presented.
- `out_lineLen`  out  6  length of the presented line (0..MAX_LEN).
- `lineOut`  out  8  current character, 0x00 at index == `out_lineLen`.
- `lineOut_nextASCII`  in  1  reader consumed `lineOut`; advance.
- `in_newASCII_ready`  in  1  the command module has reply characters pending.
- `lineIn`  in  8  reply character, 0x00 = end.
- `lineIn_nextASCII`  out  1  one-cycle pulse: `lineIn` consumed.
- `in_solved`  in  1  the command module has finished; held until `out_solved`.
- `out_solved`  out  1  one-cycle acknowledge of `in_solved`.

## Operation
- The line buffer is 32×8 with a 6-bit `len`. States: EDIT, DELIVER, TERM, WAIT, OUT, SOLVE.
- **EDIT**
  - `kb_valid` with 0x20–0x7E and `len < MAX_LEN`: store at `buf[len]`, `len++`, echo the character (`vm_we`=1, `vm_char`=char).
  - Printable character at `len == MAX_LEN`: dropped, no echo.
  - 0x08: if `len > 0`, `len--` and echo 0x08. Otherwise ignored.
  - 0x0D or 0x0A: echo 0x0A, go to DELIVER with `idx`=0.
  - Other codes: ignored.
- **DELIVER**
  - `out_newASCII_ready`=1, `out_lineLen`=`len`, `lineOut` = (`idx == len`) ? 0x00 : `buf[idx]`.
  - `lineOut_nextASCII`=1 with `idx < len`: `idx++` at that edge.
  - When `idx == len`: enter TERM.
- **TERM**
  - The terminator stays presented with `out_newASCII_ready`=1 for exactly 2 cycles in total with `idx == len`, counting the DELIVER cycle.
  - Then `out_newASCII_ready` falls and the state goes to WAIT.
  - `lineOut_nextASCII` is ignored at the terminator.
- **WAIT**
  - `in_newASCII_ready`=1: go to OUT.
  - `in_solved`=1: go to SOLVE.
- **OUT**
  - Sample when `in_newASCII_ready`=1, `lineIn` ≠ 0 and `lineIn_nextASCII` was 0 last cycle: `vm_we`=1 with `vm_char`=`lineIn`, and pulse `lineIn_nextASCII` in that same cycle.
  - At most one character every 2 cycles.
  - `in_solved`=1: go to SOLVE.
- **SOLVE**
  - `out_solved`=1 for one cycle, plus `vm_we` with 0x0A.
  - Then wait for `in_solved`=0, clear `len`, and return to EDIT. No second `out_solved` while `in_solved` stays high.
- Keystrokes outside EDIT are discarded.
- `out_newASCII_ready` is never high in WAIT, OUT or SOLVE.

## Timing
- **Reset (async, immediate):** state EDIT, `len`=`idx`=0. All outputs 0: `vm_we`, `vm_char`, `out_newASCII_ready`, `out_lineLen`, `lineOut`, `lineIn_nextASCII`, `out_solved`.
- **Reset mid-operation:** the line is abandoned and no further handshake pulses are emitted.
- **Echo latency:** `vm_we` is registered and asserted the cycle after `kb_valid`.
- **Enter to delivery:** `out_newASCII_ready` rises 1 cycle after the Enter echo.
- **Index advance:** `lineOut` shows the new character the cycle after the `lineOut_nextASCII` pulse is sampled.
- **Empty line** (`len`=0): the terminator is presented for 2 cycles, then WAIT.
- **Simultaneous `in_solved` and a pending character in OUT:** `in_solved` wins and the character is not written.
- **Width rules:** `len` and `idx` are 6-bit with no wrap, because `len` saturates at MAX_LEN.

## Test plan
- **Type and deliver:** type 'l','s',0x0D → `vm` writes 'l','s',0x0A. Then `out_lineLen`=2, and a protocol reader receives 'l','s',0x00. `out_newASCII_ready` is high 2 cycles at the terminator, then 0.
- **Backspace:** type 'a','b',0x08,'c',0x0D → delivered line "ac" with `out_lineLen`=2. Also 0x08 at `len`=0 → no echo.
- **Overflow:** 33 × 'x' then 0x0D → 31 echoes, `out_lineLen`=31, final `lineOut` 0x00.
- **Empty line:** 0x0D alone → `out_lineLen`=0 and `lineOut`=0x00 for 2 cycles.
- **Reply:** a command module replies "hi\0" then raises `in_solved` → `vm` writes 'h','i',0x0A. `lineIn_nextASCII` pulses twice, never on consecutive cycles. `out_solved` is 1 for exactly one cycle, then EDIT accepts keys.
- **Reset mid-delivery:** assert `rst_n`=0 during DELIVER at `idx`=1 → `out_newASCII_ready` drops asynchronously. After release, the state is EDIT with `len`=0.
